// File: rtl/gyr_tune_pkg.sv
// Shared types, defaults and the thermometer helper for the gyrator tuning controller.
// GYR_TUNE_TRACK_EN adds the background tracking state to the state enum.
package gyr_tune_pkg;

  localparam int NSLICE_DEF     = 10;
  localparam int SETTLE_CYC_DEF = 16;
  localparam int THERM_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DECIDE  = 3'd3
`ifdef GYR_TUNE_TRACK_EN
    , ST_TRACK = 3'd4
`endif
  } state_t;

  // Bit k set when k < code; callers truncate to their slice count.
  function automatic logic [THERM_W-1:0] therm(input logic [3:0] code);
    logic [THERM_W-1:0] t;
    t = {THERM_W{1'b0}};
    for (int k = 0; k < THERM_W; k++) begin
      if (k < int'(code)) begin
        t[k] = 1'b1;
      end else begin
        t[k] = 1'b0;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/gyr_edge_counter.sv
// Synchronizes the resonator square wave, detects rising edges and counts them
// over one 2^GATE_LOG2-cycle window per go pulse, saturating at all-ones.
module gyr_edge_counter #(
  parameter int CNT_W     = 16,
  parameter int GATE_LOG2 = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_i,
  input  logic             go,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  logic                 sync1_r;
  logic                 sync2_r;
  logic                 edge_r;
  logic                 rise_s;
  logic                 active_r;
  logic [GATE_LOG2-1:0] win_r;
  logic [CNT_W-1:0]     acc_r;
  logic [CNT_W-1:0]     base_s;
  logic [CNT_W-1:0]     acc_nxt_s;

  // Two-flop synchronizer followed by the edge-history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      edge_r  <= 1'b0;
    end else begin
      sync1_r <= osc_i;
      sync2_r <= sync1_r;
      edge_r  <= sync2_r;
    end
  end

  assign rise_s = sync2_r & ~edge_r;

  // The go cycle is the first window cycle, so accumulation restarts from zero there.
  always_comb begin
    base_s    = acc_r;
    acc_nxt_s = acc_r;
    if (go) begin
      base_s = {CNT_W{1'b0}};
    end else begin
      base_s = acc_r;
    end
    if (rise_s && (base_s != {CNT_W{1'b1}})) begin
      acc_nxt_s = base_s + CNT_W'(1'b1);
    end else begin
      acc_nxt_s = base_s;
    end
  end

  assign done  = active_r && (win_r == {GATE_LOG2{1'b1}});
  assign count = acc_nxt_s;

  // Window sequencing: go (re)starts a window, win_r wrapping to zero ends it.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r <= 1'b0;
      win_r    <= {GATE_LOG2{1'b0}};
      acc_r    <= {CNT_W{1'b0}};
    end else if (go) begin
      active_r <= 1'b1;
      win_r    <= GATE_LOG2'(1'b1);
      acc_r    <= acc_nxt_s;
    end else if (active_r) begin
      active_r <= ~done;
      win_r    <= win_r + GATE_LOG2'(1'b1);
      acc_r    <= acc_nxt_s;
    end else begin
      active_r <= 1'b0;
      win_r    <= win_r;
      acc_r    <= acc_r;
    end
  end

endmodule

// File: rtl/gyr_tune_ctrl.sv
// Gyrator bank tuning controller: linear search over the gm slice code until the
// measured edge count matches the target. GYR_TUNE_TRACK_EN enables background tracking.
module gyr_tune_ctrl
  import gyr_tune_pkg::*;
#(
  parameter int NSLICE     = NSLICE_DEF,
  parameter int CNT_W      = 16,
  parameter int GATE_LOG2  = 10,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  target_i,
  input  logic [7:0]        tol_i,
  input  logic              osc_i,
  output logic [3:0]        code_o,
  output logic [NSLICE-1:0] slice_en_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              lock_o,
  output logic              err_o
);

  localparam int              DW          = CNT_W + 1;
  localparam int              SC_W        = $clog2(SETTLE_CYC + 1);
  localparam logic [3:0]      CODE_MID    = 4'(NSLICE / 2);
  localparam logic [3:0]      CODE_MAX    = 4'(NSLICE);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYC - 1);

  state_t            state_r;
  logic [SC_W-1:0]   settle_cnt_r;
  logic              go_r;
  logic [CNT_W-1:0]  target_r;
  logic [7:0]        tol_r;
  logic [CNT_W-1:0]  count_r;
  logic [3:0]        code_r;
  logic [NSLICE-1:0] slice_en_r;
  logic              has_prev_r;
  logic              prev_up_r;
  logic [DW-1:0]     prev_adiff_r;
  logic              busy_r;
  logic              done_r;
  logic              lock_r;
  logic              err_r;

  logic              cnt_done_s;
  logic [CNT_W-1:0]  cnt_count_s;
  logic              tracking_s;
  state_t            lock_state_s;
  logic              start_ok_s;

  logic signed [DW-1:0] diff_s;
  logic [DW-1:0]        adiff_s;
  logic                 within_s;
  logic                 wide_s;
  logic                 up_s;
  logic                 rail_s;
  logic                 reversal_s;
  logic [3:0]           step_code_s;
  logic [3:0]           prev_code_s;
  logic [3:0]           restore_code_s;

  gyr_edge_counter #(
    .CNT_W     (CNT_W),
    .GATE_LOG2 (GATE_LOG2)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .osc_i (osc_i),
    .go    (go_r),
    .done  (cnt_done_s),
    .count (cnt_count_s)
  );

`ifdef GYR_TUNE_TRACK_EN
  logic tracking_r;
  assign tracking_s   = tracking_r;
  assign lock_state_s = ST_TRACK;
`else
  assign tracking_s   = 1'b0;
  assign lock_state_s = ST_IDLE;
`endif

  // While tracking the loop looks idle to the host, so a start is honoured there too.
  assign start_ok_s = start_i && ((state_r == ST_IDLE) || tracking_s);

  // Decision arithmetic on the latest completed count.
  always_comb begin
    diff_s         = $signed({1'b0, count_r}) - $signed({1'b0, target_r});
    adiff_s        = {DW{1'b0}};
    within_s       = 1'b0;
    wide_s         = 1'b0;
    up_s           = diff_s[DW-1];
    rail_s         = 1'b0;
    step_code_s    = code_r;
    prev_code_s    = code_r;
    restore_code_s = code_r;
    if (diff_s[DW-1]) begin
      adiff_s = DW'(-diff_s);
    end else begin
      adiff_s = DW'(diff_s);
    end
    within_s = (adiff_s <= DW'(tol_r));
    wide_s   = (adiff_s > DW'({tol_r, 1'b0}));
    if (up_s) begin
      rail_s      = (code_r == CODE_MAX);
      step_code_s = code_r + 4'd1;
    end else begin
      rail_s      = (code_r == 4'd0);
      step_code_s = code_r - 4'd1;
    end
    if (prev_up_r) begin
      prev_code_s = code_r - 4'd1;
    end else begin
      prev_code_s = code_r + 4'd1;
    end
    // Keep whichever code measured closer; a tie falls back to the lower code.
    if (adiff_s < prev_adiff_r) begin
      restore_code_s = code_r;
    end else if (prev_adiff_r < adiff_s) begin
      restore_code_s = prev_code_s;
    end else if (prev_code_s < code_r) begin
      restore_code_s = prev_code_s;
    end else begin
      restore_code_s = code_r;
    end
  end

  assign reversal_s = has_prev_r && (prev_up_r != up_s);

  // Calibration FSM, code register and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= {SC_W{1'b0}};
      go_r         <= 1'b0;
      target_r     <= {CNT_W{1'b0}};
      tol_r        <= 8'd0;
      count_r      <= {CNT_W{1'b0}};
      code_r       <= CODE_MID;
      slice_en_r   <= NSLICE'(therm(CODE_MID));
      has_prev_r   <= 1'b0;
      prev_up_r    <= 1'b0;
      prev_adiff_r <= {DW{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      lock_r       <= 1'b0;
      err_r        <= 1'b0;
`ifdef GYR_TUNE_TRACK_EN
      tracking_r   <= 1'b0;
`endif
    end else begin
      go_r   <= 1'b0;
      done_r <= 1'b0;
      if (start_ok_s) begin
        state_r      <= ST_SETTLE;
        settle_cnt_r <= {SC_W{1'b0}};
        target_r     <= target_i;
        tol_r        <= tol_i;
        code_r       <= CODE_MID;
        slice_en_r   <= NSLICE'(therm(CODE_MID));
        has_prev_r   <= 1'b0;
        busy_r       <= 1'b1;
        lock_r       <= 1'b0;
        err_r        <= 1'b0;
`ifdef GYR_TUNE_TRACK_EN
        tracking_r   <= 1'b0;
`endif
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_SETTLE: begin
            if (settle_cnt_r == SETTLE_LAST) begin
              state_r      <= ST_MEASURE;
              settle_cnt_r <= {SC_W{1'b0}};
              go_r         <= 1'b1;
            end else begin
              settle_cnt_r <= settle_cnt_r + SC_W'(1'b1);
            end
          end
          ST_MEASURE: begin
            if (cnt_done_s) begin
              count_r <= cnt_count_s;
              state_r <= ST_DECIDE;
            end else begin
              state_r <= ST_MEASURE;
            end
          end
          ST_DECIDE: begin
            if (tracking_s) begin
              lock_r  <= within_s;
              state_r <= lock_state_s;
              if (wide_s && !rail_s) begin
                code_r     <= step_code_s;
                slice_en_r <= NSLICE'(therm(step_code_s));
              end else begin
                code_r <= code_r;
              end
            end else if (within_s) begin
              lock_r  <= 1'b1;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= lock_state_s;
`ifdef GYR_TUNE_TRACK_EN
              tracking_r <= 1'b1;
`endif
            end else if (rail_s) begin
              err_r   <= 1'b1;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else if (reversal_s) begin
              code_r     <= restore_code_s;
              slice_en_r <= NSLICE'(therm(restore_code_s));
              lock_r     <= 1'b0;
              done_r     <= 1'b1;
              busy_r     <= 1'b0;
              state_r    <= ST_IDLE;
            end else begin
              code_r       <= step_code_s;
              slice_en_r   <= NSLICE'(therm(step_code_s));
              has_prev_r   <= 1'b1;
              prev_up_r    <= up_s;
              prev_adiff_r <= adiff_s;
              settle_cnt_r <= {SC_W{1'b0}};
              state_r      <= ST_SETTLE;
            end
          end
`ifdef GYR_TUNE_TRACK_EN
          ST_TRACK: begin
            settle_cnt_r <= {SC_W{1'b0}};
            state_r      <= ST_SETTLE;
          end
`endif
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign code_o     = code_r;
  assign slice_en_o = slice_en_r;
  assign count_o    = count_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign lock_o     = lock_r;
  assign err_o      = err_r;

endmodule

// File: tb/tb_gyr_tune_ctrl.sv
// Self-checking bench for gyr_tune_ctrl: directed scenarios plus randomized targets
// checked against a search model. The tracking scenario runs when GYR_TUNE_TRACK_EN is set.
module tb_gyr_tune_ctrl;

  localparam int MEAS_CYC = 1041;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] target_i;
  logic [7:0]  tol_i;
  logic        osc_i;
  logic [3:0]  code_o;
  logic [9:0]  slice_en_o;
  logic [15:0] count_o;
  logic        busy_o;
  logic        done_o;
  logic        lock_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;
  int osc_mult = 20;
  int phase = 0;

  gyr_tune_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .target_i   (target_i),
    .tol_i      (tol_i),
    .osc_i      (osc_i),
    .code_o     (code_o),
    .slice_en_o (slice_en_o),
    .count_o    (count_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .lock_o     (lock_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // Resonator model: osc_mult*code rising edges per 1024 cycles, via a phase accumulator.
  always @(negedge clk) begin
    phase = phase + 2 * osc_mult * int'(code_o);
    if (phase >= 1024) begin
      phase = phase - 1024;
      osc_i = ~osc_i;
    end
  end

  function automatic logic [9:0] exp_therm(input int c);
    int v;
    v = (1 << c) - 1;
    return v[9:0];
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference search: walk the code one slice at a time from mid-scale.
  task automatic model(input int mult, input int tgt, input int tol,
                       output int code, output int cnt, output bit lock,
                       output bit err, output int nmeas);
    int dir;
    int pdir;
    int d;
    int pd;
    code = 5; pdir = 0; pd = 0; nmeas = 0; lock = 0; err = 0; cnt = 0;
    for (int it = 0; it < 20; it++) begin
      cnt = mult * code;
      if (cnt > 65535) cnt = 65535;
      nmeas++;
      d = cnt - tgt;
      if (iabs(d) <= tol) begin lock = 1; break; end
      dir = (d < 0) ? 1 : -1;
      if (code + dir < 0 || code + dir > 10) begin err = 1; break; end
      if (pdir == -dir) begin
        if (iabs(pd) < iabs(d) || (iabs(pd) == iabs(d) && code - pdir < code)) code = code - pdir;
        break;
      end
      pdir = dir; pd = d; code = code + dir;
    end
  endtask

  task automatic run_cal(input int tgt, input int tol, output int cyc, output bit seen);
    @(negedge clk);
    target_i = 16'(tgt); tol_i = 8'(tol); start_i = 1'b1;
    cyc = 0; seen = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      cyc++;
      if (done_o === 1'b1) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b0; target_i = 16'd0; tol_i = 8'd0; osc_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests++; if (code_o !== 4'd5) begin fails++; $display("FAIL reset_code got %0d want 5", code_o); end
    tests++; if (slice_en_o !== 10'h01F) begin fails++; $display("FAIL reset_slice got %h want 01f", slice_en_o); end
    tests++; if (count_o !== 16'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count_o); end
    tests++; if ({busy_o, done_o, lock_o, err_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_status got %b want 0000", {busy_o, done_o, lock_o, err_o});
    end
  endtask

  task automatic test_lock_first;
    int cyc; bit seen;
    osc_mult = 20;
    run_cal(100, 5, cyc, seen);
    tests++; if (!seen || cyc != MEAS_CYC + 1) begin fails++; $display("FAIL s1_done_time got %0d (seen %0d) want %0d", cyc, seen, MEAS_CYC + 1); end
    tests++; if (count_o !== 16'd100 || code_o !== 4'd5) begin fails++; $display("FAIL s1_result got count %0d code %0d want 100/5", count_o, code_o); end
    tests++; if (lock_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL s1_status got lock %b err %b busy %b want 1/0/0", lock_o, err_o, busy_o);
    end
    @(negedge clk);
    tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL s1_done_pulse got %b want 0", done_o); end
  endtask

  task automatic test_climb_lock;
    int cyc; bit seen;
    osc_mult = 20;
    run_cal(140, 5, cyc, seen);
    tests++; if (!seen || cyc != 3 * MEAS_CYC + 1) begin fails++; $display("FAIL s2_done_time got %0d want %0d", cyc, 3 * MEAS_CYC + 1); end
    tests++; if (code_o !== 4'd7 || count_o !== 16'd140 || lock_o !== 1'b1) begin
      fails++; $display("FAIL s2_result got code %0d count %0d lock %b want 7/140/1", code_o, count_o, lock_o);
    end
    tests++; if (slice_en_o !== 10'h07F) begin fails++; $display("FAIL s2_slice got %h want 07f", slice_en_o); end
  endtask

  task automatic test_rail_err;
    int cyc; bit seen;
    osc_mult = 20;
    run_cal(300, 5, cyc, seen);
    tests++; if (!seen || cyc != 6 * MEAS_CYC + 1) begin fails++; $display("FAIL s3_done_time got %0d want %0d", cyc, 6 * MEAS_CYC + 1); end
    tests++; if (err_o !== 1'b1 || lock_o !== 1'b0) begin fails++; $display("FAIL s3_status got err %b lock %b want 1/0", err_o, lock_o); end
    tests++; if (code_o !== 4'd10 || slice_en_o !== 10'h3FF || count_o !== 16'd200) begin
      fails++; $display("FAIL s3_result got code %0d slice %h count %0d want 10/3ff/200", code_o, slice_en_o, count_o);
    end
  endtask

  task automatic test_reversal_tie;
    int cyc; bit seen;
    osc_mult = 20;
    run_cal(130, 2, cyc, seen);
    tests++; if (!seen || cyc != 3 * MEAS_CYC + 1) begin fails++; $display("FAIL s4_done_time got %0d want %0d", cyc, 3 * MEAS_CYC + 1); end
    tests++; if (code_o !== 4'd6 || slice_en_o !== 10'h03F) begin fails++; $display("FAIL s4_code got %0d slice %h want 6/03f", code_o, slice_en_o); end
    tests++; if (lock_o !== 1'b0 || err_o !== 1'b0 || count_o !== 16'd140) begin
      fails++; $display("FAIL s4_status got lock %b err %b count %0d want 0/0/140", lock_o, err_o, count_o);
    end
  endtask

  task automatic test_rst_mid_measure;
    int cyc; bit seen;
    osc_mult = 20;
    @(negedge clk);
    target_i = 16'd140; tol_i = 8'd5; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (200) @(negedge clk);
    target_i = 16'd300; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL rst_busy got %b want 1", busy_o); end
    repeat (1439) @(negedge clk);
    tests++; if (code_o !== 4'd6 || count_o !== 16'd100) begin
      fails++; $display("FAIL rst_progress got code %0d count %0d want 6/100", code_o, count_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (code_o !== 4'd5 || slice_en_o !== 10'h01F || count_o !== 16'd0) begin
      fails++; $display("FAIL rst_values got code %0d slice %h count %0d want 5/01f/0", code_o, slice_en_o, count_o);
    end
    tests++; if ({busy_o, done_o, lock_o, err_o} !== 4'b0000) begin
      fails++; $display("FAIL rst_status got %b want 0000", {busy_o, done_o, lock_o, err_o});
    end
    repeat (1200) @(negedge clk);
    tests++; if (busy_o !== 1'b0 || count_o !== 16'd0 || code_o !== 4'd5) begin
      fails++; $display("FAIL rst_quiet got busy %b count %0d code %0d want 0/0/5", busy_o, count_o, code_o);
    end
    run_cal(140, 5, cyc, seen);
    tests++; if (!seen || code_o !== 4'd7 || lock_o !== 1'b1 || count_o !== 16'd140) begin
      fails++; $display("FAIL rst_relock got seen %0d code %0d lock %b count %0d want 1/7/1/140", seen, code_o, lock_o, count_o);
    end
  endtask

  task automatic test_random;
    int cyc; bit seen;
    int tgt; int tol; int ecode; int ecnt; bit elock; bit eerr; int enm;
    for (int r = 0; r < 3; r++) begin
      osc_mult = int'($urandom_range(12, 24));
      tgt = int'($urandom_range(0, osc_mult * 10 + 20));
      tol = int'($urandom_range(0, 12));
      model(osc_mult, tgt, tol, ecode, ecnt, elock, eerr, enm);
      run_cal(tgt, tol, cyc, seen);
      tests++; if (!seen || cyc != enm * MEAS_CYC + 1) begin
        fails++; $display("FAIL rnd%0d_time got %0d want %0d (mult %0d tgt %0d tol %0d)", r, cyc, enm * MEAS_CYC + 1, osc_mult, tgt, tol);
      end
      tests++; if (int'(code_o) != ecode || slice_en_o !== exp_therm(ecode) || int'(count_o) != ecnt) begin
        fails++; $display("FAIL rnd%0d_result got code %0d count %0d want %0d/%0d", r, code_o, count_o, ecode, ecnt);
      end
      tests++; if (lock_o !== elock || err_o !== eerr) begin
        fails++; $display("FAIL rnd%0d_status got lock %b err %b want %b/%b", r, lock_o, err_o, elock, eerr);
      end
    end
  endtask

`ifdef GYR_TUNE_TRACK_EN
  task automatic test_track;
    int cyc; bit seen; bit extra_done; bit saw_unlock;
    osc_mult = 20;
    run_cal(100, 5, cyc, seen);
    tests++; if (!seen || lock_o !== 1'b1 || code_o !== 4'd5) begin
      fails++; $display("FAIL trk_lock got seen %0d lock %b code %0d want 1/1/5", seen, lock_o, code_o);
    end
    osc_mult = 16;
    extra_done = 1'b0; saw_unlock = 1'b0;
    for (int i = 0; i < 2300; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) extra_done = 1'b1;
      if (lock_o === 1'b0) saw_unlock = 1'b1;
    end
    tests++; if (extra_done || busy_o !== 1'b0) begin fails++; $display("FAIL trk_quiet got done %b busy %b want 0/0", extra_done, busy_o); end
    tests++; if (code_o !== 4'd6 || count_o !== 16'd96 || lock_o !== 1'b1 || !saw_unlock) begin
      fails++; $display("FAIL trk_step got code %0d count %0d lock %b unlock %b want 6/96/1/1", code_o, count_o, lock_o, saw_unlock);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock_first();
    test_climb_lock();
    test_rail_err();
    test_reversal_tie();
    test_rst_mid_measure();
    test_random();
`ifdef GYR_TUNE_TRACK_EN
    test_track();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
